// File: rtl/as_jtag_master.sv
// JTAG TAP initiator: after reset it walks the TAP to Run-Test/Idle, then
// performs one IR scan plus one DR scan per request and returns to idle.
module as_jtag_master #(
  parameter int IR_WIDTH = 5,
  parameter int DR_WIDTH = 64,
  parameter int CLK_DIV  = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [IR_WIDTH-1:0]           ir_i,
  input  logic [DR_WIDTH-1:0]           dr_i,
  input  logic [$clog2(DR_WIDTH+1)-1:0] dr_len_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o,
  output logic [DR_WIDTH-1:0]           dr_o,
  output logic                          tck_o,
  output logic                          tms_o,
  output logic                          tdi_o,
  output logic                          trst_o,
  input  logic                          tdo_i
);
  localparam int LEN_W = $clog2(DR_WIDTH+1);
  localparam int DRI_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
  localparam int IRI_W = (IR_WIDTH > 1) ? $clog2(IR_WIDTH) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_IR_HDR, S_IR_SHIFT, S_IR_TAIL, S_DR_HDR, S_DR_SHIFT, S_DR_TAIL
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d, trst_q, trst_d;
  logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [2:0]          seq_q, seq_d;
  logic [IRI_W-1:0]    ir_cnt_q, ir_cnt_d;
  logic [DRI_W-1:0]    dr_cnt_q, dr_cnt_d;
  logic [IR_WIDTH-1:0] ir_sh_q, ir_sh_d;
  logic [DR_WIDTH-1:0] dr_sh_q, dr_sh_d, dr_q, dr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                toggle, rise, fall, ir_last, dr_last, len_ok;
  logic [LEN_W-1:0]    dr_last_idx;

  // Request handshake: start_i is taken only in idle (busy_o=0); an accepted
  // request raises busy_o the next cycle and ends with done_o as busy_o drops.
  assign len_ok      = (dr_len_i != '0) && (dr_len_i <= LEN_W'(DR_WIDTH));
  assign toggle      = busy_q && !trst_q && (div_q == DIV_W'(CLK_DIV-1));
  assign rise        = toggle && !tck_q;
  assign fall        = toggle && tck_q;
  assign dr_last_idx = len_q - LEN_W'(1);
  assign ir_last     = (ir_cnt_q == IRI_W'(IR_WIDTH-1));
  assign dr_last     = (LEN_W'(dr_cnt_q) == dr_last_idx);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_INIT;
      div_q    <= '0;
      tck_q    <= 1'b0;
      tms_q    <= 1'b1;
      tdi_q    <= 1'b0;
      trst_q   <= 1'b1;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      seq_q    <= '0;
      ir_cnt_q <= '0;
      dr_cnt_q <= '0;
      ir_sh_q  <= '0;
      dr_sh_q  <= '0;
      dr_q     <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      tck_q    <= tck_d;
      tms_q    <= tms_d;
      tdi_q    <= tdi_d;
      trst_q   <= trst_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      seq_q    <= seq_d;
      ir_cnt_q <= ir_cnt_d;
      dr_cnt_q <= dr_cnt_d;
      ir_sh_q  <= ir_sh_d;
      dr_sh_q  <= dr_sh_d;
      dr_q     <= dr_d;
      len_q    <= len_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tck_d    = tck_q;
    tms_d    = tms_q;
    tdi_d    = tdi_q;
    trst_d   = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    seq_d    = seq_q;
    ir_cnt_d = ir_cnt_q;
    dr_cnt_d = dr_cnt_q;
    ir_sh_d  = ir_sh_q;
    dr_sh_d  = dr_sh_q;
    dr_d     = dr_q;
    len_d    = len_q;
    // The divider holds off for the cycle in which trst is released.
    if (busy_q && !trst_q) div_d = toggle ? '0 : div_q + DIV_W'(1);
    else                   div_d = '0;
    if (toggle) tck_d = !tck_q;
    if (rise && state_q == S_DR_SHIFT) dr_d[dr_cnt_q] = tdo_i;

    // Each branch acts on the falling TCK edge that closes the current bit
    // and sets up tms/tdi for the next one.
    case (state_q)
      S_INIT: if (fall) begin
        if (seq_q == 3'd5) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          tms_d   = 1'b0;
        end else begin
          seq_d = seq_q + 3'd1;
          tms_d = (seq_q < 3'd4);
        end
      end
      S_IDLE: if (start_i) begin
        if (len_ok) begin
          ir_sh_d = ir_i;
          dr_sh_d = dr_i;
          len_d   = dr_len_i;
          dr_d    = '0;
          busy_d  = 1'b1;
          seq_d   = '0;
          tms_d   = 1'b1;
          state_d = S_IR_HDR;
        end else begin
          err_d = 1'b1;
        end
      end
      S_IR_HDR: if (fall) begin
        if (seq_q == 3'd3) begin
          state_d  = S_IR_SHIFT;
          ir_cnt_d = '0;
          tms_d    = (IR_WIDTH == 1);
          tdi_d    = ir_sh_q[0];
          ir_sh_d  = ir_sh_q >> 1;
        end else begin
          seq_d = seq_q + 3'd1;
          tms_d = (seq_q == 3'd0);
        end
      end
      S_IR_SHIFT: if (fall) begin
        if (ir_last) begin
          state_d = S_IR_TAIL;
          seq_d   = '0;
          tms_d   = 1'b1;
          tdi_d   = 1'b0;
        end else begin
          ir_cnt_d = ir_cnt_q + IRI_W'(1);
          tms_d    = (ir_cnt_q == IRI_W'(IR_WIDTH-2));
          tdi_d    = ir_sh_q[0];
          ir_sh_d  = ir_sh_q >> 1;
        end
      end
      S_IR_TAIL: if (fall) begin
        if (seq_q == 3'd1) begin
          state_d = S_DR_HDR;
          seq_d   = '0;
          tms_d   = 1'b0;
        end else begin
          seq_d = 3'd1;
          tms_d = 1'b1;
        end
      end
      S_DR_HDR: if (fall) begin
        if (seq_q == 3'd1) begin
          state_d  = S_DR_SHIFT;
          dr_cnt_d = '0;
          tms_d    = (len_q == LEN_W'(1));
          tdi_d    = dr_sh_q[0];
          dr_sh_d  = dr_sh_q >> 1;
        end else begin
          seq_d = 3'd1;
          tms_d = 1'b0;
        end
      end
      S_DR_SHIFT: if (fall) begin
        if (dr_last) begin
          state_d = S_DR_TAIL;
          seq_d   = '0;
          tms_d   = 1'b1;
          tdi_d   = 1'b0;
        end else begin
          dr_cnt_d = dr_cnt_q + DRI_W'(1);
          tms_d    = (LEN_W'(dr_cnt_q) + LEN_W'(1) == dr_last_idx);
          tdi_d    = dr_sh_q[0];
          dr_sh_d  = dr_sh_q >> 1;
        end
      end
      S_DR_TAIL: if (fall) begin
        if (seq_q == 3'd1) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          tms_d   = 1'b0;
        end else begin
          seq_d = 3'd1;
          tms_d = 1'b0;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;
  assign dr_o   = dr_q;
  assign tck_o  = tck_q;
  assign tms_o  = tms_q;
  assign tdi_o  = tdi_q;
  assign trst_o = trst_q;
endmodule
